// File: rtl/rvv_lsu_bridge_pkg.sv
// Shared types and constants for the RVV<->LSU uop bridge.
// The registered-uop struct is sized for the default beat (16 bytes) and a
// 32-bit address; the bridge parameters must not exceed these widths.
package rvv_lsu_bridge_pkg;

  localparam int LSU_BEAT_BYTES = 16;
  localparam int LSU_DATA_W     = 8 * LSU_BEAT_BYTES;
  localparam int LSU_ADDR_W     = 32;

  // Bridge FSM: accept a uop, issue one memory request, optionally wait for
  // the read response, optionally return one beat to the vector core.
  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_RSP  = 2'd2,
    LSU_WB   = 2'd3
  } LsuBridgeStateT;

  // Uop fields captured at accept. The address is stored already aligned to
  // the beat and the strobe is the effective one (mask applied).
  typedef struct packed {
    logic                      store;
    logic [LSU_ADDR_W-1:0]     addr;
    logic [4:0]                vreg;
    logic [LSU_DATA_W-1:0]     data;
    logic [LSU_BEAT_BYTES-1:0] strb;
    logic                      last;
  } LsuBridgeUopT;

endpackage

// File: rtl/rvv_lsu_strb_gen.sv
// Combinational byte-strobe helper for the RVV LSU bridge.
// - Effective strobe: the v0 byte mask when it applies, otherwise all bytes.
// - Zero flag: the effective strobe selects no byte at all.
// - Load merge: bytes not selected by the registered strobe read back as
//   8'hFF (mask-agnostic fill), selected bytes pass the memory data through.
module rvv_lsu_strb_gen
  import rvv_lsu_bridge_pkg::*;
#(
  parameter int VLEN_B = LSU_BEAT_BYTES
) (
  input  logic                  v0_valid,
  input  logic [VLEN_B-1:0]     v0,
  output logic [VLEN_B-1:0]     strb,
  output logic                  strb_zero,
  input  logic [VLEN_B-1:0]     merge_strb,
  input  logic [8*VLEN_B-1:0]   rdata,
  output logic [8*VLEN_B-1:0]   merged
);

  // Effective strobe for the uop being offered, plus its all-zero flag.
  always_comb begin
    strb      = v0_valid ? v0 : '1;
    strb_zero = (strb == '0);
  end

  // Mask-agnostic merge of returned load data.
  always_comb begin
    merged = '1;
    for (int b = 0; b < VLEN_B; b++) begin
      if (merge_strb[b]) begin
        merged[8*b +: 8] = rdata[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/rvv_lsu_bridge.sv
// LSU-side responder for the RVV<->LSU uop interface.
// One vector load/store uop at a time becomes one beat-wide memory request.
// Loads return their (mask-merged) data to the vector register file as a
// writeback beat; the final store uop of an instruction returns a last beat.
//
// Handshake semantics (uop, mem_req, wb): a transfer happens on a rising
// clock edge where valid and ready are both 1. A producer holding valid high
// keeps its payload stable until that edge; ready may change freely. Memory
// read responses carry no ready and are only consumed while in RSP.
//
// Optional feature macro: RVV_LSU_SKIP_MASKED_EN. When defined, a store whose
// effective strobe is all-zero issues no memory request (a last store then
// goes straight to its completion beat). When undefined every uop issues
// exactly one request.
//
// All outputs come straight from flops; the handshake flags are loaded from
// the next-state value so that e.g. a uop accepted at cycle t shows
// mem_req_valid_o at t+1.
module rvv_lsu_bridge
  import rvv_lsu_bridge_pkg::*;
#(
  parameter int ADDR_W = LSU_ADDR_W,
  parameter int VLEN_B = LSU_BEAT_BYTES
) (
  input  logic                 clk,
  input  logic                 rstn,
  // uop from the vector core
  input  logic                 uop_valid_i,
  output logic                 uop_ready_o,
  input  logic                 uop_store_i,
  input  logic [ADDR_W-1:0]    uop_addr_i,
  input  logic [4:0]           uop_vreg_i,
  input  logic [8*VLEN_B-1:0]  uop_sdata_i,
  input  logic                 uop_v0_valid_i,
  input  logic [VLEN_B-1:0]    uop_v0_i,
  input  logic                 uop_last_i,
  // in-order memory port
  output logic                 mem_req_valid_o,
  input  logic                 mem_req_ready_i,
  output logic                 mem_req_write_o,
  output logic [ADDR_W-1:0]    mem_req_addr_o,
  output logic [8*VLEN_B-1:0]  mem_req_wdata_o,
  output logic [VLEN_B-1:0]    mem_req_wstrb_o,
  input  logic                 mem_rsp_valid_i,
  input  logic [8*VLEN_B-1:0]  mem_rsp_rdata_i,
  // writeback / completion beat to the vector core
  output logic                 wb_valid_o,
  output logic [4:0]           wb_addr_o,
  output logic [8*VLEN_B-1:0]  wb_data_o,
  output logic                 wb_last_o,
  input  logic                 wb_ready_i,
  // status
  output logic                 idle_o,
  output LsuBridgeStateT       dbg_state_o
);

  localparam int DATA_W = 8 * VLEN_B;
  // Clears the byte-offset bits of a beat address.
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(VLEN_B - 1);

`ifdef RVV_LSU_SKIP_MASKED_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif

  LsuBridgeStateT      state_q;
  LsuBridgeStateT      state_d;
  LsuBridgeUopT        uop_q;

  logic                uop_ready_q;
  logic                idle_q;
  logic                req_valid_q;
  logic                wb_valid_q;
  logic                wb_last_q;
  logic [4:0]          wb_addr_q;
  logic [DATA_W-1:0]   wb_data_q;

  logic                accept;
  logic                skip;
  logic [VLEN_B-1:0]   strb_eff;
  logic                strb_zero;
  logic [DATA_W-1:0]   rsp_merged;

  logic                wb_load;
  logic                wb_last_d;
  logic [4:0]          wb_addr_d;
  logic [DATA_W-1:0]   wb_data_d;

  rvv_lsu_strb_gen #(
    .VLEN_B (VLEN_B)
  ) u_strb_gen (
    .v0_valid   (uop_v0_valid_i),
    .v0         (uop_v0_i),
    .strb       (strb_eff),
    .strb_zero  (strb_zero),
    .merge_strb (VLEN_B'(uop_q.strb)),
    .rdata      (mem_rsp_rdata_i),
    .merged     (rsp_merged)
  );

  // uop_ready_q is only ever high in IDLE, so this is the uop transfer.
  assign accept = uop_valid_i & uop_ready_q;
  // A fully masked store may bypass the memory port when the feature is on.
  assign skip   = SKIP_EN & uop_store_i & strb_zero;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LSU_IDLE: begin
        if (accept) begin
          if (skip) begin
            state_d = uop_last_i ? LSU_WB : LSU_IDLE;
          end else begin
            state_d = LSU_REQ;
          end
        end
      end
      LSU_REQ: begin
        if (mem_req_ready_i) begin
          if (!uop_q.store) begin
            state_d = LSU_RSP;
          end else if (uop_q.last) begin
            state_d = LSU_WB;
          end else begin
            state_d = LSU_IDLE;
          end
        end
      end
      LSU_RSP: begin
        if (mem_rsp_valid_i) begin
          state_d = LSU_WB;
        end
      end
      LSU_WB: begin
        if (wb_ready_i) begin
          state_d = LSU_IDLE;
        end
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  // Payload of the writeback beat, loaded only on entry to WB.
  always_comb begin
    wb_load   = 1'b0;
    wb_last_d = 1'b0;
    wb_addr_d = uop_q.vreg;
    wb_data_d = '0;
    if ((state_q == LSU_RSP) && mem_rsp_valid_i) begin
      wb_load   = 1'b1;
      wb_data_d = rsp_merged;
    end else if ((state_q == LSU_REQ) && mem_req_ready_i && uop_q.store && uop_q.last) begin
      wb_load   = 1'b1;
      wb_last_d = 1'b1;
    end else if (accept && skip && uop_last_i) begin
      wb_load   = 1'b1;
      wb_last_d = 1'b1;
      wb_addr_d = uop_vreg_i;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= LSU_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture the uop at accept; it also drives the memory request payload.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      uop_q <= '0;
    end else if (accept) begin
      uop_q <= '{
        store: uop_store_i,
        addr:  LSU_ADDR_W'(uop_addr_i & ALIGN_MASK),
        vreg:  uop_vreg_i,
        data:  LSU_DATA_W'(uop_sdata_i),
        strb:  LSU_BEAT_BYTES'(strb_eff),
        last:  uop_last_i
      };
    end
  end

  // Registered handshake and status flags, derived from the next state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      uop_ready_q <= 1'b0;
      idle_q      <= 1'b1;
      req_valid_q <= 1'b0;
      wb_valid_q  <= 1'b0;
    end else begin
      uop_ready_q <= (state_d == LSU_IDLE);
      idle_q      <= (state_d == LSU_IDLE);
      req_valid_q <= (state_d == LSU_REQ);
      wb_valid_q  <= (state_d == LSU_WB);
    end
  end

  // Writeback beat payload, held while the beat waits for wb_ready_i.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wb_last_q <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else if (wb_load) begin
      wb_last_q <= wb_last_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign uop_ready_o     = uop_ready_q;
  assign idle_o          = idle_q;
  assign dbg_state_o     = state_q;

  assign mem_req_valid_o = req_valid_q;
  assign mem_req_write_o = uop_q.store;
  assign mem_req_addr_o  = ADDR_W'(uop_q.addr);
  assign mem_req_wdata_o = DATA_W'(uop_q.data);
  assign mem_req_wstrb_o = VLEN_B'(uop_q.strb);

  assign wb_valid_o      = wb_valid_q;
  assign wb_last_o       = wb_last_q;
  assign wb_addr_o       = wb_addr_q;
  assign wb_data_o       = wb_data_q;

endmodule

// File: tb/tb_rvv_lsu_bridge.sv
// Self-checking bench for rvv_lsu_bridge: directed cases from the test plan
// followed by randomized uops with random memory/writeback backpressure.
// Expected request and beat contents come from a small behavioural model.
module tb_rvv_lsu_bridge;
  import rvv_lsu_bridge_pkg::*;

  localparam int ADDR_W = 32;
  localparam int VLEN_B = 16;
  localparam int DATA_W = 8 * VLEN_B;

`ifdef RVV_LSU_SKIP_MASKED_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic                uop_valid;
  logic                uop_ready;
  logic                uop_store;
  logic [ADDR_W-1:0]   uop_addr;
  logic [4:0]          uop_vreg;
  logic [DATA_W-1:0]   uop_sdata;
  logic                uop_v0_valid;
  logic [VLEN_B-1:0]   uop_v0;
  logic                uop_last;
  logic                mem_req_valid;
  logic                mem_req_ready;
  logic                mem_req_write;
  logic [ADDR_W-1:0]   mem_req_addr;
  logic [DATA_W-1:0]   mem_req_wdata;
  logic [VLEN_B-1:0]   mem_req_wstrb;
  logic                mem_rsp_valid;
  logic [DATA_W-1:0]   mem_rsp_rdata;
  logic                wb_valid;
  logic [4:0]          wb_addr;
  logic [DATA_W-1:0]   wb_data;
  logic                wb_last;
  logic                wb_ready;
  logic                idle;
  LsuBridgeStateT      dbg_state;

  rvv_lsu_bridge #(
    .ADDR_W (ADDR_W),
    .VLEN_B (VLEN_B)
  ) dut (
    .clk             (clk),
    .rstn            (rstn),
    .uop_valid_i     (uop_valid),
    .uop_ready_o     (uop_ready),
    .uop_store_i     (uop_store),
    .uop_addr_i      (uop_addr),
    .uop_vreg_i      (uop_vreg),
    .uop_sdata_i     (uop_sdata),
    .uop_v0_valid_i  (uop_v0_valid),
    .uop_v0_i        (uop_v0),
    .uop_last_i      (uop_last),
    .mem_req_valid_o (mem_req_valid),
    .mem_req_ready_i (mem_req_ready),
    .mem_req_write_o (mem_req_write),
    .mem_req_addr_o  (mem_req_addr),
    .mem_req_wdata_o (mem_req_wdata),
    .mem_req_wstrb_o (mem_req_wstrb),
    .mem_rsp_valid_i (mem_rsp_valid),
    .mem_rsp_rdata_i (mem_rsp_rdata),
    .wb_valid_o      (wb_valid),
    .wb_addr_o       (wb_addr),
    .wb_data_o       (wb_data),
    .wb_last_o       (wb_last),
    .wb_ready_i      (wb_ready),
    .idle_o          (idle),
    .dbg_state_o     (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int req_cnt  = 0;
  int wb_cnt   = 0;
  int acc_cnt  = 0;
  int exp_req  = 0;
  int exp_wb   = 0;
  logic [DATA_W-1:0] exp_q[$];

  // Handshake monitors: count every transfer the DUT actually makes.
  always @(posedge clk) begin
    if (rstn) begin
      if (uop_valid && uop_ready)         acc_cnt <= acc_cnt + 1;
      if (mem_req_valid && mem_req_ready) req_cnt <= req_cnt + 1;
      if (wb_valid && wb_ready)           wb_cnt  <= wb_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [VLEN_B-1:0] model_strb(input bit v0v, input logic [VLEN_B-1:0] v0);
    return v0v ? v0 : {VLEN_B{1'b1}};
  endfunction

  // Unselected bytes of load data read back as 0xFF.
  function automatic logic [DATA_W-1:0] model_load(input logic [DATA_W-1:0] rdata,
                                                   input logic [VLEN_B-1:0] strb);
    logic [DATA_W-1:0] r;
    for (int b = 0; b < VLEN_B; b++) r[8*b +: 8] = strb[b] ? rdata[8*b +: 8] : 8'hFF;
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- drivers ----------------
  task automatic wait_uop_ready();
    int guard;
    guard = 0;
    while (uop_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("uop_ready_idle", uop_ready, 1'b1);
  endtask

  // Drives one uop through the whole bridge and checks every visible phase.
  // Called at a negedge with the bridge idle; returns at a negedge, idle.
  task automatic run_uop(input bit store, input logic [ADDR_W-1:0] addr,
                         input logic [4:0] vreg, input logic [DATA_W-1:0] sdata,
                         input bit v0v, input logic [VLEN_B-1:0] v0, input bit last,
                         input logic [DATA_W-1:0] rdata, input int req_stall,
                         input int rsp_delay, input int wb_stall);
    logic [VLEN_B-1:0] strb;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_data;
    bit has_req;
    bit has_wb;
    strb     = model_strb(v0v, v0);
    has_req  = !(SKIP && store && (strb == '0));
    has_wb   = !store || last;
    exp_addr = addr - (addr % VLEN_B);

    wait_uop_ready();
    uop_store = store; uop_addr = addr; uop_vreg = vreg; uop_sdata = sdata;
    uop_v0_valid = v0v; uop_v0 = v0; uop_last = last; uop_valid = 1'b1;
    @(negedge clk);
    // Scramble the uop bus so a late capture would be caught.
    uop_valid = 1'b0; uop_addr = $urandom; uop_sdata = rnd_data();
    uop_v0 = VLEN_B'($urandom); uop_vreg = 5'($urandom);

    if (has_req) begin
      exp_req++;
      for (int i = 0; i <= req_stall; i++) begin
        check("req_valid", mem_req_valid, 1'b1);
        check("req_write", mem_req_write, store);
        check("req_addr", mem_req_addr, exp_addr);
        if (store) begin
          check("req_wdata", mem_req_wdata, sdata);
          check("req_wstrb", mem_req_wstrb, strb);
        end
        check("uop_ready_busy", uop_ready, 1'b0);
        check("idle_busy", idle, 1'b0);
        mem_req_ready = (i == req_stall);
        // Stray responses while the request is pending must be ignored.
        mem_rsp_valid = (i < req_stall) ? 1'($urandom_range(0, 1)) : 1'b0;
        mem_rsp_rdata = rnd_data();
        @(negedge clk);
      end
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
    end else begin
      check("req_skipped", mem_req_valid, 1'b0);
    end

    if (has_wb) exp_q.push_back(store ? '0 : model_load(rdata, strb));

    if (!store) begin
      for (int i = 0; i < rsp_delay; i++) begin
        check("wb_early", wb_valid, 1'b0);
        @(negedge clk);
      end
      mem_rsp_valid = 1'b1; mem_rsp_rdata = rdata;
      @(negedge clk);
      mem_rsp_valid = 1'b0; mem_rsp_rdata = rnd_data();
    end

    if (has_wb) begin
      exp_wb++;
      exp_data = exp_q.pop_front();
      for (int i = 0; i <= wb_stall; i++) begin
        check("wb_valid", wb_valid, 1'b1);
        check("wb_last", wb_last, store);
        if (!store) check("wb_addr", wb_addr, vreg);
        check("wb_data", wb_data, exp_data);
        check("uop_ready_wb", uop_ready, 1'b0);
        check("req_valid_wb", mem_req_valid, 1'b0);
        wb_ready = (i == wb_stall);
        @(negedge clk);
      end
      wb_ready = 1'b0;
    end else begin
      check("wb_none", wb_valid, 1'b0);
    end
    check("uop_ready_done", uop_ready, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DATA_W-1:0] sd;
    int r0;
    int w0;
    int a0;
    uop_valid = 1'b0; uop_store = 1'b0; uop_addr = '0; uop_vreg = '0;
    uop_sdata = '0; uop_v0_valid = 1'b0; uop_v0 = '0; uop_last = 1'b0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0; wb_ready = 1'b0;

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_uop_ready", uop_ready, 1'b0);
    check("rst_req_valid", mem_req_valid, 1'b0);
    check("rst_req_addr", mem_req_addr, '0);
    check("rst_req_wdata", mem_req_wdata, '0);
    check("rst_req_wstrb", mem_req_wstrb, '0);
    check("rst_wb_valid", wb_valid, 1'b0);
    check("rst_wb_data", wb_data, '0);
    check("rst_wb_last", wb_last, 1'b0);
    check("rst_idle", idle, 1'b1);
    check("rst_state", dbg_state, LSU_IDLE);
    rstn = 1'b1;
    @(negedge clk);
    check("ready_after_reset", uop_ready, 1'b1);

    // Plain load, no mask.
    run_uop(1'b0, 32'h1000, 5'd5, '0, 1'b0, '0, 1'b0,
            128'h0123456789ABCDEFFEDCBA9876543210, 0, 0, 0);
    // Masked store with last, then the same uop without last.
    sd = rnd_data();
    run_uop(1'b1, 32'h2004, 5'd0, sd, 1'b1, 16'h00FF, 1'b1, '0, 0, 0, 0);
    run_uop(1'b1, 32'h2004, 5'd0, sd, 1'b1, 16'h00FF, 1'b0, '0, 0, 0, 0);
    // Masked load of all-zero data: selected bytes 0x00, the rest 0xFF.
    run_uop(1'b0, 32'h3000, 5'd7, '0, 1'b1, 16'hF0F0, 1'b0, '0, 0, 1, 0);
    // All-zero mask load: still one request, data reads all 0xFF.
    run_uop(1'b0, 32'h3010, 5'd8, '0, 1'b1, 16'h0000, 1'b0, rnd_data(), 0, 0, 0);

    // Backpressure: exactly one request and one beat per uop.
    r0 = req_cnt; w0 = wb_cnt;
    run_uop(1'b0, 32'h4000, 5'd9, '0, 1'b0, '0, 1'b0, rnd_data(), 5, 2, 3);
    check("bp_load_reqs", req_cnt - r0, 1);
    check("bp_load_wbs", wb_cnt - w0, 1);
    r0 = req_cnt; w0 = wb_cnt;
    run_uop(1'b1, 32'h4010, 5'd3, rnd_data(), 1'b0, '0, 1'b1, '0, 5, 0, 3);
    check("bp_store_reqs", req_cnt - r0, 1);
    check("bp_store_wbs", wb_cnt - w0, 1);

    // Fully masked last store (request skipped only with the feature on).
    r0 = req_cnt;
    run_uop(1'b1, 32'h5000, 5'd1, rnd_data(), 1'b1, 16'h0000, 1'b1, '0, 0, 0, 0);
    check("zero_strb_reqs", req_cnt - r0, SKIP ? 0 : 1);

    // Randomized uops with random stalls and stray responses while idle.
    for (int n = 0; n < 40; n++) begin
      logic [VLEN_B-1:0] m;
      m = ($urandom_range(0, 3) == 0) ? '0 : VLEN_B'($urandom);
      run_uop(1'($urandom_range(0, 1)), $urandom, 5'($urandom), rnd_data(),
              1'($urandom_range(0, 1)), m, 1'($urandom_range(0, 1)), rnd_data(),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        mem_rsp_valid = 1'b1; mem_rsp_rdata = rnd_data();
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        check("idle_stray_rsp", wb_valid, 1'b0);
      end
    end

    // Throughput: back-to-back non-last stores, one uop per two cycles.
    a0 = acc_cnt; r0 = req_cnt;
    uop_store = 1'b1; uop_last = 1'b0; uop_v0_valid = 1'b0; uop_addr = 32'h6000;
    uop_valid = 1'b1; mem_req_ready = 1'b1;
    repeat (8) @(negedge clk);
    uop_valid = 1'b0; mem_req_ready = 1'b0;
    check("tput_accepts", acc_cnt - a0, 4);
    check("tput_reqs", req_cnt - r0, 4);
    check("tput_ready", uop_ready, 1'b1);
    exp_req += 4;

    // Reset while waiting for a load response, then a stale response.
    wait_uop_ready();
    uop_store = 1'b0; uop_addr = 32'h7000; uop_vreg = 5'd11; uop_v0_valid = 1'b0;
    uop_last = 1'b0; uop_valid = 1'b1;
    @(negedge clk);
    uop_valid = 1'b0;
    check("rr_req_valid", mem_req_valid, 1'b1);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    exp_req++;
    check("rr_in_rsp", idle, 1'b0);
    w0 = wb_cnt;
    rstn = 1'b0;
    #1;
    check("rr_uop_ready", uop_ready, 1'b0);
    check("rr_req_valid_rst", mem_req_valid, 1'b0);
    check("rr_req_addr", mem_req_addr, '0);
    check("rr_wb_valid", wb_valid, 1'b0);
    check("rr_wb_data", wb_data, '0);
    check("rr_idle", idle, 1'b1);
    @(negedge clk);
    rstn = 1'b1;
    mem_rsp_valid = 1'b1; mem_rsp_rdata = rnd_data();
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    check("rr_stale_wb", wb_valid, 1'b0);
    check("rr_idle_after", idle, 1'b1);
    check("rr_ready_after", uop_ready, 1'b1);
    repeat (2) @(negedge clk);
    check("rr_no_beat", wb_cnt - w0, 0);

    // ---------------- final report ----------------
    check("total_reqs", req_cnt, exp_req);
    check("total_wbs", wb_cnt, exp_wb);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rvv_lsu_bridge.md
# rvv_lsu_bridge

LSU-side responder for the RVV↔LSU uop interface exported by the RVV core. It accepts one vector load/store uop at a time and turns it into a single 128-bit memory request. Load data is returned to the vector register file as a writeback beat; completion of the final store uop of an instruction is signalled as a last beat. It sits between the core's `uop_lsu_*_rvv2lsu` / `uop_lsu_*_lsu2rvv` ports and a simple in-order memory port.

## Interface
Parameters:
- `ADDR_W`, default 32: memory byte-address width.
- `VLEN_B`, default 16: bytes per vector register beat. Data width is `8*VLEN_B`; strobe width is `VLEN_B`.

Ports:
- `clk` in 1: clock.
- `rstn` in 1: one clock; reset is asynchronous and active-low.
- `uop_valid_i` in 1: uop offered by RVV.
- `uop_ready_o` out 1: bridge accepts the uop.
- `uop_store_i` in 1: 1 = store, 0 = load.
- `uop_addr_i` in ADDR_W: beat base address, `VLEN_B`-aligned.
- `uop_vreg_i` in 5: destination vreg (load).
- `uop_sdata_i` in 8*VLEN_B: store data (vregfile read data).
- `uop_v0_valid_i` in 1: mask applies.
- `uop_v0_i` in VLEN_B: byte mask.
- `uop_last_i` in 1: final uop of the instruction.
- `mem_req_valid_o` out 1: memory request.
- `mem_req_ready_i` in 1: memory accepts the request.
- `mem_req_write_o` out 1: write request.
- `mem_req_addr_o` out ADDR_W: request address.
- `mem_req_wdata_o` out 8*VLEN_B: write data.
- `mem_req_wstrb_o` out VLEN_B: byte strobe.
- `mem_rsp_valid_i` in 1: read response.
- `mem_rsp_rdata_i` in 8*VLEN_B: read data.
- `wb_valid_o` out 1: beat to RVV; maps to `uop_lsu_valid_lsu2rvv`.
- `wb_addr_o` out 5: vreg address.
- `wb_data_o` out 8*VLEN_B: load data.
- `wb_last_o` out 1: store-complete beat; maps to `uop_lsu_last_lsu2rvv`.
- `wb_ready_i` in 1: RVV accepts the beat.
- `idle_o` out 1: FSM is in IDLE.

## Operation
- FSM states: IDLE, REQ, RSP, WB.
- IDLE:
  - `uop_ready_o`=1.
  - On `uop_valid_i`: register all uop fields and go to REQ.
- Strobe: `uop_v0_valid_i ? uop_v0_i : all-ones`. Computed at accept and registered.
- REQ:
  - `mem_req_valid_o`=1.
  - `mem_req_addr_o` = registered address with its low `log2(VLEN_B)` bits forced to 0.
  - On `mem_req_ready_i`:
    - load → RSP.
    - store with last → WB.
    - store without last → IDLE.
- RSP:
  - On `mem_rsp_valid_i`, register the data and go to WB.
  - Masked-off bytes of returned load data are forced to 8'hFF (mask-agnostic).
- WB: `wb_valid_o`=1.
  - Load beat: `wb_last_o`=0, `wb_addr_o`=vreg, `wb_data_o`=merged data.
  - Store beat: `wb_last_o`=1, `wb_data_o`=0.
  - On `wb_ready_i` → IDLE.
- Boundary conditions:
  - `mem_rsp_valid_i` outside RSP is ignored.
  - Reset mid-operation abandons the uop. A late response then arrives in IDLE and is ignored.
  - All-zero mask on a load still issues the request; the returned data is all 8'hFF.
  - Only one transaction is ever outstanding.

## Timing
- Reset values:
  - All valid outputs 0.
  - Data/addr/strobe outputs 0.
  - `uop_ready_o`=0 during reset, 1 in the first cycle after release.
  - `idle_o`=1.
- Latency:
  - Uop accepted at cycle t → `mem_req_valid_o` at t+1.
  - Response at cycle r → `wb_valid_o` at r+1.
- Throughput: non-last store with `mem_req_ready_i` held at 1 = one uop per 2 cycles.
- Handshake rules:
  - All outputs are registered.
  - `mem_req_*` are stable while valid and not ready.
  - `wb_*` are stable while valid and not ready.
  - `uop_ready_o` is 0 in every state except IDLE.

## Configuration
- Macro: `RVV_LSU_SKIP_MASKED_EN`.
- Defined: a store whose effective strobe is all-zero issues no memory request.
  - With last → go straight to WB (last beat at t+1).
  - Without last → stay in IDLE; the uop is consumed in one cycle.
- Undefined: every uop issues exactly one memory request, including zero-strobe writes.

## Structure
- Shared package `rvv_lsu_bridge_pkg` holds:
  - state enum `LsuBridgeStateT`.
  - registered-uop struct `LsuBridgeUopT` (store, addr, vreg, data, strb, last).
  - constant `LSU_BEAT_BYTES`=16.
- One sub-module is natural: `rvv_lsu_strb_gen`.
  - Combinational.
  - Produces the effective strobe and the all-zero flag from v0 valid/mask.
  - Also performs the load-data 8'hFF merge.

## Test plan
- Load, addr 0x1000, vreg 5, no mask, rsp data 0x0123…EF, both readies high:
  - req at t+1: write=0, addr 0x1000.
  - WB at rsp+1: addr 5, data unchanged, last=0.
- Store, addr 0x2004, mask 0x00FF, last=1:
  - request: addr 0x2000, wstrb 0x00FF, wdata = sdata.
  - one WB beat with last=1.
  - no WB for a repeat uop with last=0.
- Load with mask 0xF0F0, rsp all-zero → `wb_data_o` bytes 4–7 and 12–15 = 0x00, others = 0xFF.
- Backpressure:
  - `mem_req_ready_i` low 5 cycles, then `wb_ready_i` low 3 cycles.
  - Outputs stay stable and `uop_ready_o` stays 0 throughout.
  - Exactly one request and one WB beat.
- Reset asserted while in RSP, then a stale `mem_rsp_valid_i`:
  - all outputs at reset values, `idle_o`=1.
  - no WB beat.
- Store with mask 0x0000, last=1:
  - with `RVV_LSU_SKIP_MASKED_EN`: no `mem_req_valid_o`, last beat at t+1.
  - without it: one request with wstrb 0, then the last beat.
